bcd_scan_driver: RTL
====================

Name: bcd_scan_driver

Overview:
- Upstream feeder for the BCD-to-7-segment decoder on a multiplexed multi-digit display.
- Accepts a binary value on a load strobe and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine.
- Holds the result in a display register and time-multiplexes one digit at a time onto a 4-bit bcd bus, plus an active-low digit-enable vector.
- The decoder consumes bcd combinationally. Codes above 9 (e.g. 4'hF) are rendered blank by the decoder.

Parameters:
- DIGITS, 4: number of display digits, range 1..8.
- BIN_W, 14: width of the binary input.
- MAX_VAL, 9999: largest displayable value. Must equal 10^DIGITS-1.
- REFRESH_DIV, 50000: clk cycles per digit slot. Must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bin_in  in  BIN_W  binary value to display, sampled on load.
- load  in  1  single-cycle strobe: start a conversion of bin_in.
- busy  out  1  high while a conversion is in progress.
- ovf  out  1  high if the last accepted value exceeded MAX_VAL.
- bcd  out  4  BCD code of the currently scanned digit, to the decoder.
- an  out  DIGITS  active-low digit enables, one-hot low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - busy=0, ovf=0, bcd=4'h0.
  - an = all ones except bit0 = 0, so digit 0 is selected.
  - Display register = all zero.
  - Scan index = 0, prescaler = 0, FSM = IDLE.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - On load=1, capture min(bin_in, MAX_VAL) into the shift register and clear the BCD accumulator.
  - Set ovf = (bin_in > MAX_VAL), set busy=1, go to SHIFT.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {accumulator, binary} left by 1.
  - Stays exactly BIN_W cycles (bit counter BIN_W-1 down to 0), then goes to COMMIT.
- COMMIT:
  - Copy the accumulator into the display register, clear busy, return to IDLE.
- Latency: load sampled at edge N. The display register holds the new value after edge N+BIN_W+1. busy is high for edges N+1 .. N+BIN_W+1 inclusive, i.e. BIN_W+1 cycles.
- load while busy=1 is ignored. No queuing, and ovf is unchanged.
- The display register changes only in COMMIT, so the scanned digits never show partial results.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, the scan index advances (DIGITS-1 wraps to 0).
  - an and bcd are registered and update on the same edge as the index: an[idx]=0 with the others 1, and bcd = display digit idx (digit 0 = least significant).
- Scan runs continuously and independently of the FSM. A COMMIT is reflected on the current digit at the next index change.
- rst asserted mid-conversion aborts the conversion; all state returns to reset values on that edge.

Optional Feature:
- Macro: BCD_SCAN_LZ_BLANK_EN.
- Defined: while scanning digit i (i>0), bcd is driven to 4'hF if all display digits i..DIGITS-1 are zero. Digit 0 is never blanked, so the value 0 shows as a single "0".
- Undefined: all digits are always driven with their BCD value, leading zeros included.

Test Plan:
- Reset check: assert rst for 2 cycles -> busy=0, ovf=0, bcd=0, an=4'b1110. Scan then cycles an 1110→1101→1011→0111→1110 with bcd=0 throughout (REFRESH_DIV=4).
- Load 1234: pulse load with bin_in=1234 -> busy high for exactly 15 cycles. Afterwards, the scan shows bcd 4,3,2,1 with an 1110,1101,1011,0111; ovf=0.
- Saturation: load 16383 -> after 15 cycles the digits read 9,9,9,9 and ovf=1. A following load of 42 -> ovf=0 and digits 2,4,0,0 (with BCD_SCAN_LZ_BLANK_EN: 2,4,F,F).
- Load during busy: load 500, then load 7 three cycles later -> second load ignored; final digits 0,0,5,0; busy deasserts at the original time.
- Reset mid-conversion: load 9999, assert rst 5 cycles later -> busy=0, display register=0, no COMMIT. A later load of 1 converts correctly to 1,0,0,0.
- Zero display with BCD_SCAN_LZ_BLANK_EN defined: load 0 -> bcd sequence 0,F,F,F. With the macro undefined: 0,0,0,0.

Source files
------------

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: binary-to-BCD feeder for a multiplexed 7-segment display.
//
// A load strobe captures bin_in, saturated to MAX_VAL. A sequential
// shift-add-3 (double-dabble) engine converts it to packed BCD. The result
// is committed in one step to a display register. A free-running scanner
// then presents one digit at a time on bcd, with a one-hot-low enable on an.
//
// Ports:
//   clk     in   1       system clock, rising edge
//   rst     in   1       synchronous, active-high reset
//   bin_in  in   BIN_W   binary value, sampled when load is accepted
//   load    in   1       single-cycle strobe; ignored while busy
//   busy    out  1       conversion in progress
//   ovf     out  1       last accepted value exceeded MAX_VAL
//   bcd     out  4       BCD code of the scanned digit
//   an      out  DIGITS  active-low digit enables
//
// Optional build macro: BCD_SCAN_LZ_BLANK_EN
//   When defined, leading zero digits (all digits i..DIGITS-1 zero, i>0)
//   are driven as 4'hF, which the downstream decoder renders blank.
//   When undefined, every digit is driven with its BCD value.

module bcd_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned MAX_VAL     = 9999,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        bcd,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ACC_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BIN_W-1:0] SAT_VAL  = BIN_W'(MAX_VAL);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Conversion state
  logic [1:0]             state, state_nxt;
  logic                   busy_nxt, ovf_nxt;
  logic [BIN_W-1:0]       shreg, shreg_nxt;
  logic [DIGITS-1:0][3:0] acc, acc_nxt, bcd_adj;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [DIGITS-1:0][3:0] disp, disp_nxt;
  logic                   over_c;

  // Scan state
  logic [PRE_W-1:0]       pre, pre_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [DIGITS-1:0]      an_nxt;
  logic [3:0]             bcd_nxt;

  // Wide compare so MAX_VAL may exceed the range of bin_in.
  assign over_c = (64'(bin_in) > 64'(MAX_VAL));

  // Conversion FSM: next-state and datapath
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    ovf_nxt   = ovf;
    shreg_nxt = shreg;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    disp_nxt  = disp;

    // Add-3 correction on every nibble >= 5 before the shift.
    bcd_adj = acc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (acc[d] >= 4'd5) begin
        bcd_adj[d] = acc[d] + 4'd3;
      end
    end

    case (state)
      S_IDLE: begin
        if (load) begin
          shreg_nxt = over_c ? SAT_VAL : bin_in;
          acc_nxt   = '0;
          cnt_nxt   = CNT_LAST;
          ovf_nxt   = over_c;
          busy_nxt  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Shift {accumulator, binary} left by one.
        acc_nxt   = ACC_W'({bcd_adj, shreg[BIN_W-1]});
        shreg_nxt = {shreg[BIN_W-2:0], 1'b0};
        cnt_nxt   = cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Display updates atomically, never with partial results.
        disp_nxt  = acc;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Conversion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      ovf   <= 1'b0;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      disp  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      ovf   <= ovf_nxt;
      shreg <= shreg_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      disp  <= disp_nxt;
    end
  end

`ifdef BCD_SCAN_LZ_BLANK_EN
  // zero_from[i]: display digits i..DIGITS-1 are all zero.
  logic [DIGITS:0] zero_from;

  always_comb begin
    zero_from         = '0;
    zero_from[DIGITS] = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (disp[i] == 4'd0);
    end
  end
`endif

  // Scan: prescaler wrap advances the digit index; an/bcd follow it.
  always_comb begin
    pre_nxt = pre;
    idx_nxt = idx;
    an_nxt  = an;
    bcd_nxt = bcd;
    if (pre == PRE_LAST) begin
      pre_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      an_nxt  = ~(DIGITS'(1) << idx_nxt);
      bcd_nxt = disp[idx_nxt];
`ifdef BCD_SCAN_LZ_BLANK_EN
      if ((idx_nxt != '0) && zero_from[idx_nxt]) begin
        bcd_nxt = 4'hF;
      end
`endif
    end else begin
      pre_nxt = pre + PRE_W'(1);
    end
  end

  // Scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      an  <= ~DIGITS'(1);
      bcd <= 4'h0;
    end else begin
      pre <= pre_nxt;
      idx <= idx_nxt;
      an  <= an_nxt;
      bcd <= bcd_nxt;
    end
  end

endmodule
